// File: rtl/byte_mem_ctrl_if.sv
// Request, write-data, read-data, response and memory-beat signals
// shared by the burst sequencer and its neighbours.
interface byte_mem_ctrl_if #(
    parameter int ADDR_SIZE  = 32,
    parameter int WORD_SIZE  = 32,
    parameter int STRB_BITS  = 4,
    parameter int BURST_BITS = 2
);
    logic                  reqValid;
    logic                  reqReady;
    logic [ADDR_SIZE-1:0]  reqAddr;
    logic                  reqWr;
    logic [STRB_BITS-1:0]  reqStrb;
    logic [BURST_BITS-1:0] reqBurstLen;
    logic                  wdValid;
    logic                  wdReady;
    logic [WORD_SIZE-1:0]  wdData;
    logic                  rdValid;
    logic [WORD_SIZE-1:0]  rdData;
    logic                  respValid;
    logic                  respErr;
    logic [ADDR_SIZE-1:0]  memAddr;
    logic [WORD_SIZE-1:0]  memDataIn;
    logic [STRB_BITS-1:0]  memStrb;
    logic                  memWr;
    logic                  memReq;
    logic                  memBusy;
    logic [WORD_SIZE-1:0]  memDataOut;

    modport slave (
        input  reqValid, reqAddr, reqWr, reqStrb, reqBurstLen,
        input  wdValid, wdData, memBusy, memDataOut,
        output reqReady, wdReady, rdValid, rdData,
        output respValid, respErr,
        output memAddr, memDataIn, memStrb, memWr, memReq
    );

    modport master (
        output reqValid, reqAddr, reqWr, reqStrb, reqBurstLen,
        output wdValid, wdData, memBusy, memDataOut,
        input  reqReady, wdReady, rdValid, rdData,
        input  respValid, respErr,
        input  memAddr, memDataIn, memStrb, memWr, memReq
    );
endinterface

// File: rtl/byte_mem_ctrl.sv
// Burst request sequencer in front of the banked byte memory:
// one memory beat per word, single response pulse per burst.
module byte_mem_ctrl #(
    parameter int ADDR_SIZE      = 32,
    parameter int WORD_SIZE      = 32,
    parameter int STRB_BITS      = 4,
    parameter int BURST_BITS     = 2,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TIMEOUT_BITS   = 5
) (
    input  logic           i_clk,
    input  logic           i_reset,
    byte_mem_ctrl_if.slave io_bus
);
    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RECOVER, RESP
    } state_t;

    state_t                r_state;
    logic                  r_reqReady;
    logic                  r_rdValid;
    logic                  r_respValid;
    logic                  r_respErr;
    logic                  r_wr;
    logic [ADDR_SIZE-1:0]  r_addr;
    logic [WORD_SIZE-1:0]  r_dataIn;
    logic [WORD_SIZE-1:0]  r_rdData;
    logic [STRB_BITS-1:0]  r_strb;
    logic [BURST_BITS:0]   r_beats;
    logic [TIMEOUT_BITS-1:0] r_tmo;

    logic w_issue;
    logic w_wdHs;
    logic w_last;
    logic w_tmoHit;

    assign w_issue  = (r_state == ISSUE);
    assign w_wdHs   = w_issue & r_wr & io_bus.wdValid;
    assign w_last   = (r_beats == (BURST_BITS+1)'(1));
    assign w_tmoHit = (r_tmo == TIMEOUT_BITS'(TIMEOUT_CYCLES - 1));

    // A write beat is only requested once its data is actually present.
    assign io_bus.memReq    = w_issue & (~r_wr | io_bus.wdValid);
    assign io_bus.wdReady   = w_wdHs;
    assign io_bus.reqReady  = r_reqReady;
    assign io_bus.rdValid   = r_rdValid;
    assign io_bus.rdData    = r_rdData;
    assign io_bus.respValid = r_respValid;
    assign io_bus.respErr   = r_respErr;
    assign io_bus.memAddr   = r_addr;
    assign io_bus.memDataIn = r_dataIn;
    assign io_bus.memStrb   = r_strb;
    assign io_bus.memWr     = r_wr;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_reqReady  <= 1'b1;
            r_rdValid   <= 1'b0;
            r_respValid <= 1'b0;
            r_respErr   <= 1'b0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_dataIn    <= '0;
            r_rdData    <= '0;
            r_strb      <= '0;
            r_beats     <= '0;
            r_tmo       <= '0;
        end else begin
            r_rdValid   <= 1'b0;
            r_respValid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (io_bus.reqValid) begin
                        r_addr     <= {io_bus.reqAddr[ADDR_SIZE-1:2], 2'b00};
                        r_wr       <= io_bus.reqWr;
                        r_strb     <= io_bus.reqWr ? io_bus.reqStrb : '1;
                        r_beats    <= (BURST_BITS+1)'(io_bus.reqBurstLen)
                                      + (BURST_BITS+1)'(1);
                        r_respErr  <= 1'b0;
                        r_reqReady <= 1'b0;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!r_wr || io_bus.wdValid) begin
                        if (r_wr) r_dataIn <= io_bus.wdData;
                        r_tmo   <= '0;
                        r_state <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (io_bus.memBusy) begin
                        r_tmo   <= '0;
                        r_state <= WAIT_DONE;
                    end else if (w_tmoHit) begin
                        r_respValid <= 1'b1;
                        r_respErr   <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_tmo <= r_tmo + TIMEOUT_BITS'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!io_bus.memBusy) begin
                        if (!r_wr) begin
                            r_rdData  <= io_bus.memDataOut;
                            r_rdValid <= 1'b1;
                        end
                        r_addr  <= r_addr + ADDR_SIZE'(4);
                        r_beats <= r_beats - (BURST_BITS+1)'(1);
                        if (w_last) begin
                            r_respValid <= 1'b1;
                            r_state     <= RESP;
                        end else begin
                            r_state <= RECOVER;
                        end
                    end else if (w_tmoHit) begin
                        r_respValid <= 1'b1;
                        r_respErr   <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_tmo <= r_tmo + TIMEOUT_BITS'(1);
                    end
                end
                RECOVER: r_state <= ISSUE;
                RESP: begin
                    r_reqReady <= 1'b1;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Directed bench for byte_mem_ctrl with a small busy-handshake
// memory model and logs of memory beats, read data and responses.
module tb_byte_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    byte_mem_ctrl_if bus ();

    byte_mem_ctrl #(
        .ADDR_SIZE(32), .WORD_SIZE(32), .STRB_BITS(4),
        .BURST_BITS(2), .TIMEOUT_CYCLES(16), .TIMEOUT_BITS(5)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .io_bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [31:0] mem [64];
    logic        mem_en = 1'b1;
    int          lat    = 1;
    logic        m_busy = 1'b0;
    int          m_rem  = 0;
    logic [31:0] m_addr = '0;
    logic        m_wr   = 1'b0;
    logic [3:0]  m_strb = '0;

    logic [31:0] req_addr[$];
    logic        req_wr[$];
    logic [3:0]  req_strb[$];
    int          req_cyc[$];
    logic [31:0] rd_q[$];
    logic        resp_q[$];
    int          resp_cyc[$];

    logic [31:0] wq[$];
    logic        wd_hs    = 1'b0;
    int          wd_beat  = 0;
    int          gap_beat = -1;
    int          gap_len  = 0;
    int          gap_left = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Monitor and memory model, sampled 2 ns after the rising edge.
    always @(posedge clk) begin
        #2;
        cyc++;
        if (rst) begin
            m_busy = 1'b0;
            wd_hs  = 1'b0;
            bus.memDataOut = '0;
        end else begin
            if (bus.memReq) begin
                req_addr.push_back(bus.memAddr);
                req_wr.push_back(bus.memWr);
                req_strb.push_back(bus.memStrb);
                req_cyc.push_back(cyc);
            end
            if (bus.rdValid) rd_q.push_back(bus.rdData);
            if (bus.respValid) begin
                resp_q.push_back(bus.respErr);
                resp_cyc.push_back(cyc);
            end
            wd_hs = bus.wdValid && bus.wdReady;
            if (m_busy) begin
                if (m_rem == 0) begin
                    m_busy = 1'b0;
                    if (m_wr) begin
                        for (int b = 0; b < 4; b++)
                            if (m_strb[b])
                                mem[m_addr[7:2]][8*b +: 8] =
                                    bus.memDataIn[8*b +: 8];
                    end else begin
                        bus.memDataOut = mem[m_addr[7:2]];
                    end
                end else begin
                    m_rem--;
                end
            end else if (bus.memReq && mem_en) begin
                m_busy = 1'b1;
                m_rem  = lat;
                m_addr = bus.memAddr;
                m_wr   = bus.memWr;
                m_strb = bus.memStrb;
            end
        end
        bus.memBusy = m_busy;
    end

    // Write-data source with an optional stall before one beat.
    always @(posedge clk) begin
        #1;
        if (wd_hs) begin
            void'(wq.pop_front());
            wd_beat++;
            if (wd_beat == gap_beat) gap_left = gap_len;
        end
        if (gap_left > 0) begin
            bus.wdValid = 1'b0;
            gap_left--;
        end else if (wq.size() > 0) begin
            bus.wdValid = 1'b1;
            bus.wdData  = wq[0];
        end else begin
            bus.wdValid = 1'b0;
            bus.wdData  = '0;
        end
    end

    task automatic clr_logs();
        req_addr.delete(); req_wr.delete();
        req_strb.delete(); req_cyc.delete();
        rd_q.delete(); resp_q.delete(); resp_cyc.delete();
        wd_beat = 0; gap_beat = -1; gap_left = 0;
    endtask

    task automatic send_req(input logic [31:0] a, input logic wr,
                            input logic [3:0] s, input logic [1:0] l);
        int n;
        @(posedge clk); #1;
        bus.reqValid    = 1'b1;
        bus.reqAddr     = a;
        bus.reqWr       = wr;
        bus.reqStrb     = s;
        bus.reqBurstLen = l;
        n = 0;
        while (!bus.reqReady && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_accept", 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        bus.reqValid = 1'b0;
    endtask

    task automatic wait_resp(input int cnt);
        int n;
        n = 0;
        while (resp_q.size() < cnt && n < 300) begin
            @(posedge clk); #3;
            n++;
        end
        chk("resp_seen", 32'(resp_q.size() >= cnt), 32'd1);
    endtask

    initial begin
        bus.reqValid    = 1'b0;
        bus.reqAddr     = '0;
        bus.reqWr       = 1'b0;
        bus.reqStrb     = '0;
        bus.reqBurstLen = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        chk("rst_reqReady", 32'(bus.reqReady), 32'd1);
        chk("rst_memReq", 32'(bus.memReq), 32'd0);
        chk("rst_respValid", 32'(bus.respValid), 32'd0);
        chk("rst_rdValid", 32'(bus.rdValid), 32'd0);
        chk("rst_memAddr", bus.memAddr, 32'h0);

        // single write then read-back
        clr_logs();
        wq.push_back(32'hDEADBEEF);
        send_req(32'h10, 1'b1, 4'hF, 2'd0);
        wait_resp(1);
        chk("w1_nreq", 32'(req_addr.size()), 32'd1);
        chk("w1_addr", req_addr[0], 32'h10);
        chk("w1_wr", 32'(req_wr[0]), 32'd1);
        chk("w1_err", 32'(resp_q[0]), 32'd0);
        chk("w1_mem", mem[4], 32'hDEADBEEF);
        repeat (2) @(posedge clk);
        clr_logs();
        send_req(32'h10, 1'b0, 4'h0, 2'd0);
        wait_resp(1);
        @(posedge clk); #3;
        chk("r1_nrd", 32'(rd_q.size()), 32'd1);
        chk("r1_data", rd_q[0], 32'hDEADBEEF);
        chk("r1_strb", 32'(req_strb[0]), 32'hF);

        // 4-beat read
        mem[8] = 32'h11112222; mem[9]  = 32'h33334444;
        mem[10] = 32'h55556666; mem[11] = 32'h77778888;
        repeat (2) @(posedge clk);
        clr_logs();
        send_req(32'h20, 1'b0, 4'h0, 2'd3);
        wait_resp(1);
        @(posedge clk); #3;
        chk("r4_nreq", 32'(req_addr.size()), 32'd4);
        chk("r4_addr1", req_addr[1], 32'h24);
        chk("r4_addr3", req_addr[3], 32'h2C);
        chk("r4_gap1", 32'(req_cyc[1] - req_cyc[0]), 32'd4);
        chk("r4_gap3", 32'(req_cyc[3] - req_cyc[2]), 32'd4);
        chk("r4_nrd", 32'(rd_q.size()), 32'd4);
        chk("r4_d0", rd_q[0], 32'h11112222);
        chk("r4_d3", rd_q[3], 32'h77778888);
        chk("r4_nresp", 32'(resp_q.size()), 32'd1);
        chk("r4_err", 32'(resp_q[0]), 32'd0);

        // 3-beat write with stalled second beat
        repeat (2) @(posedge clk);
        clr_logs();
        gap_beat = 1; gap_len = 9;
        wq.push_back(32'hA0A0A0A0);
        wq.push_back(32'hB1B1B1B1);
        wq.push_back(32'hC2C2C2C2);
        send_req(32'h40, 1'b1, 4'hF, 2'd2);
        wait_resp(1);
        chk("w3_nreq", 32'(req_addr.size()), 32'd3);
        chk("w3_gap1", 32'(req_cyc[1] - req_cyc[0]), 32'd10);
        chk("w3_gap2", 32'(req_cyc[2] - req_cyc[1]), 32'd4);
        chk("w3_err", 32'(resp_q[0]), 32'd0);
        chk("w3_m0", mem[16], 32'hA0A0A0A0);
        chk("w3_m1", mem[17], 32'hB1B1B1B1);
        chk("w3_m2", mem[18], 32'hC2C2C2C2);

        // timeout: memory never goes busy
        repeat (2) @(posedge clk);
        clr_logs();
        mem_en = 1'b0;
        send_req(32'h50, 1'b0, 4'h0, 2'd1);
        wait_resp(1);
        chk("to_err", 32'(resp_q[0]), 32'd1);
        chk("to_lat", 32'(resp_cyc[0] - req_cyc[0]), 32'd17);
        chk("to_nreq", 32'(req_addr.size()), 32'd1);
        chk("to_nrd", 32'(rd_q.size()), 32'd0);
        @(posedge clk); #3;
        chk("to_reqReady", 32'(bus.reqReady), 32'd1);
        mem_en = 1'b1;

        // address wrap with unaligned start
        mem[63] = 32'hCAFEF00D; mem[0] = 32'h0BADC0DE;
        repeat (2) @(posedge clk);
        clr_logs();
        send_req(32'hFFFFFFFE, 1'b0, 4'h0, 2'd1);
        wait_resp(1);
        @(posedge clk); #3;
        chk("wr_addr0", req_addr[0], 32'hFFFFFFFC);
        chk("wr_addr1", req_addr[1], 32'h00000000);
        chk("wr_d0", rd_q[0], 32'hCAFEF00D);
        chk("wr_d1", rd_q[1], 32'h0BADC0DE);

        // reset during the second beat's done phase
        mem[32] = 32'h01020304; mem[33] = 32'h05060708;
        repeat (2) @(posedge clk);
        clr_logs();
        lat = 3;
        send_req(32'h80, 1'b0, 4'h0, 2'd3);
        begin
            int n;
            n = 0;
            while (req_addr.size() < 2 && n < 100) begin
                @(posedge clk); #3;
                n++;
            end
            chk("rs_beat2", 32'(req_addr.size() >= 2), 32'd1);
        end
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        #2;
        chk("rs_memReq", 32'(bus.memReq), 32'd0);
        chk("rs_reqReady", 32'(bus.reqReady), 32'd1);
        repeat (8) @(posedge clk);
        #3;
        chk("rs_noresp", 32'(resp_q.size()), 32'd0);
        chk("rs_nrd", 32'(rd_q.size()), 32'd1);
        lat = 1;
        clr_logs();
        send_req(32'h84, 1'b0, 4'h0, 2'd0);
        wait_resp(1);
        @(posedge clk); #3;
        chk("rs_new_err", 32'(resp_q[0]), 32'd0);
        chk("rs_new_data", rd_q[0], 32'h05060708);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
